// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the contact-bounce emulator: state encodings, LFSR taps
// and the LFSR step function reused by pattern generators and benches.
`timescale 1ns/1ps
package bounce_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BOUNCE  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_ILLEGAL = 2'd3
  } bounce_state_e;

  localparam int LFSR_W  = 8;
  localparam int COUNT_W = 4;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_generator_if.sv
// Level-in / bouncy-out bundle of the bounce emulator; the stimulus side uses
// master, the emulator itself uses slave.
`timescale 1ns/1ps
interface bounce_generator_if;
  import bounce_generator_pkg::*;

  logic               clean_in;
  logic               enable;
  logic               bouncy_out;
  logic               busy;
  logic [COUNT_W-1:0] toggle_count_out;
  logic [1:0]         state_out;

  modport master (
    output clean_in, enable,
    input  bouncy_out, busy, toggle_count_out, state_out
  );

  modport slave (
    input  clean_in, enable,
    output bouncy_out, busy, toggle_count_out, state_out
  );

endinterface

// File: rtl/bounce_lfsr.sv
// Free-running 8-bit Fibonacci LFSR with a configurable nonzero seed.
`timescale 1ns/1ps
module bounce_lfsr
  import bounce_generator_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns a clean level change into an odd-length burst of
// pseudo-random-width glitch segments followed by a settle window.
`timescale 1ns/1ps
module bounce_generator
  import bounce_generator_pkg::*;
#(
  parameter int                BOUNCE_PAIRS  = 2,
  parameter int                MIN_HOLD      = 3,
  parameter logic [3:0]        HOLD_MASK     = 4'hF,
  parameter int                SETTLE_CYCLES = 16,
  parameter int                CNT_W         = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  bounce_generator_if.slave bus
);

  localparam logic [COUNT_W-1:0] TOTAL_TOGGLES = COUNT_W'(2 * BOUNCE_PAIRS + 1);
  localparam logic [CNT_W-1:0]   MIN_HOLD_M1   = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0]   SETTLE_M1     = CNT_W'(SETTLE_CYCLES - 1);

  bounce_state_e      state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               bouncy_q, bouncy_d;
  logic               busy_q, busy_d;

  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_unused;
  logic [CNT_W-1:0]   seg_m1;
  logic [COUNT_W-1:0] count_inc;
  logic               start;
  bounce_state_e      launch_state;
  logic [CNT_W-1:0]   launch_timer;

  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:4];
  assign seg_m1      = MIN_HOLD_M1 + CNT_W'(lfsr[3:0] & HOLD_MASK);
  assign count_inc   = count_q + COUNT_W'(1);
  assign start       = bus.enable && (bus.clean_in != bouncy_q);

  // With no bounce pairs the first toggle is also the last, so go straight to settle
  assign launch_state = (TOTAL_TOGGLES == COUNT_W'(1)) ? ST_SETTLE : ST_BOUNCE;
  assign launch_timer = (TOTAL_TOGGLES == COUNT_W'(1)) ? SETTLE_M1 : seg_m1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    bouncy_d = bouncy_q;

    if (!bus.enable) begin
      state_d  = ST_IDLE;
      timer_d  = '0;
      count_d  = '0;
      bouncy_d = bus.clean_in;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bouncy_d = !bouncy_q;
            count_d  = COUNT_W'(1);
            timer_d  = launch_timer;
            state_d  = launch_state;
          end
        end

        ST_BOUNCE: begin
          if (timer_q == '0) begin
            bouncy_d = !bouncy_q;
            count_d  = count_inc;
            if (count_inc >= TOTAL_TOGGLES) begin
              timer_d = SETTLE_M1;
              state_d = ST_SETTLE;
            end else begin
              timer_d = seg_m1;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end

        // A difference pending at settle expiry launches the next episode on the same edge
        ST_SETTLE: begin
          if (timer_q == '0) begin
            if (start) begin
              bouncy_d = !bouncy_q;
              count_d  = COUNT_W'(1);
              timer_d  = launch_timer;
              state_d  = launch_state;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      bouncy_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      bouncy_q <= bouncy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.bouncy_out       = bouncy_q;
  assign bus.busy             = busy_q;
  assign bus.toggle_count_out = count_q;
  assign bus.state_out        = state_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: a fixed-width instance and a random-width instance
// share stimulus and are both checked every cycle against an episode-schedule model.
`timescale 1ns/1ps
module tb_bounce_generator;
  import bounce_generator_pkg::*;

  localparam int PAIRS  = 2;
  localparam int MINH   = 3;
  localparam int SETTLE = 8;
  localparam int TOTAL  = 2 * PAIRS + 1;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic clean  = 1'b0;
  logic enable = 1'b1;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  bounce_generator_if bus_det ();
  bounce_generator_if bus_rnd ();

  assign bus_det.clean_in = clean;
  assign bus_det.enable   = enable;
  assign bus_rnd.clean_in = clean;
  assign bus_rnd.enable   = enable;

  bounce_generator #(
    .BOUNCE_PAIRS (PAIRS), .MIN_HOLD (MINH), .HOLD_MASK (4'h0),
    .SETTLE_CYCLES (SETTLE), .CNT_W (8), .LFSR_SEED (8'hA5)
  ) dut_det (
    .clk (clk), .reset (reset), .bus (bus_det)
  );

  bounce_generator #(
    .BOUNCE_PAIRS (PAIRS), .MIN_HOLD (MINH), .HOLD_MASK (4'hF),
    .SETTLE_CYCLES (SETTLE), .CNT_W (8), .LFSR_SEED (8'hA5)
  ) dut_rnd (
    .clk (clk), .reset (reset), .bus (bus_rnd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_no <= 0;
    else       edge_no <= edge_no + 1;
  end

  logic       d_out [2];
  logic       d_busy[2];
  logic [3:0] d_cnt [2];
  logic [1:0] d_st  [2];
  assign d_out[0]  = bus_det.bouncy_out;
  assign d_out[1]  = bus_rnd.bouncy_out;
  assign d_busy[0] = bus_det.busy;
  assign d_busy[1] = bus_rnd.busy;
  assign d_cnt[0]  = bus_det.toggle_count_out;
  assign d_cnt[1]  = bus_rnd.toggle_count_out;
  assign d_st[0]   = bus_det.state_out;
  assign d_st[1]   = bus_rnd.state_out;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_no);
    end
  endtask

  // ---------------- behavioural model: per-episode toggle schedule ----------------
  logic [3:0] mask_of [2];
  logic       m_out   [2];
  logic       m_act   [2];
  int         m_cnt   [2];
  logic [7:0] m_lfsr  [2];
  int         tog_edge[2][TOTAL];
  int         tog_idx [2];
  int         end_edge[2];
  int         me;

  initial begin
    mask_of[0] = 4'h0;
    mask_of[1] = 4'hF;
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] lfsr_after(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = lfsr_next(r);
    return r;
  endfunction

  task automatic model_launch(input int i, input int e);
    int t;
    t = e;
    m_out[i] = !m_out[i];
    m_cnt[i] = 1;
    m_act[i] = 1'b1;
    tog_edge[i][0] = e;
    for (int k = 1; k < TOTAL; k++) begin
      t = t + MINH + int'(lfsr_after(m_lfsr[i], t - e) & {4'h0, mask_of[i]});
      tog_edge[i][k] = t;
    end
    tog_idx[i]  = 1;
    end_edge[i] = t + SETTLE;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        me = 0;
        for (int i = 0; i < 2; i++) begin
          m_out[i] = 1'b0; m_act[i] = 1'b0; m_cnt[i] = 0;
          m_lfsr[i] = 8'hA5; tog_idx[i] = TOTAL; end_edge[i] = -1;
        end
      end else begin
        me = me + 1;
        for (int i = 0; i < 2; i++) begin
          if (!enable) begin
            m_out[i] = clean; m_act[i] = 1'b0; m_cnt[i] = 0; tog_idx[i] = TOTAL;
          end else if (m_act[i]) begin
            if (tog_idx[i] < TOTAL && tog_edge[i][tog_idx[i]] == me) begin
              m_out[i] = !m_out[i];
              m_cnt[i] = m_cnt[i] + 1;
              tog_idx[i] = tog_idx[i] + 1;
            end else if (me == end_edge[i]) begin
              if (clean != m_out[i]) model_launch(i, me);
              else begin m_act[i] = 1'b0; m_cnt[i] = 0; end
            end
          end else if (clean != m_out[i]) begin
            model_launch(i, me);
          end
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
        end
      end
    end
  end

  // Compare both instances against the model on every cycle outside reset
  initial begin
    string nm[2];
    nm[0] = "det";
    nm[1] = "rnd";
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          checkOutput({nm[i], "_out"},   int'(d_out[i]),  int'(m_out[i]));
          checkOutput({nm[i], "_busy"},  int'(d_busy[i]), int'(m_act[i]));
          checkOutput({nm[i], "_count"}, int'(d_cnt[i]),  m_cnt[i]);
          checkOutput({nm[i], "_state"}, int'(d_st[i]),
                      !m_act[i] ? 0 : (tog_idx[i] < TOTAL ? 1 : 2));
        end
      end
    end
  end

  // ---------------- recorders ----------------
  int   det_tog[$];
  int   busy_rise, busy_fall;
  logic det_prev;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        det_prev = 1'b0;
      end else begin
        if (bus_det.bouncy_out != det_prev) det_tog.push_back(edge_no);
        if (bus_det.busy && busy_rise < 0) busy_rise = edge_no;
        if (!bus_det.busy && busy_rise >= 0 && busy_fall < 0) busy_fall = edge_no;
        det_prev = bus_det.bouncy_out;
      end
    end
  end

  bit   rnd_phase = 1'b0;
  int   rnd_eps   = 0;
  int   rnd_last_tog, rnd_last_cnt;
  logic rnd_prev, rnd_level_before;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rnd_prev = 1'b0;
      end else begin
        if (rnd_phase && bus_rnd.bouncy_out != rnd_prev) begin
          if (bus_rnd.toggle_count_out == 4'd1) begin
            if (rnd_eps > 0) checkOutput("episode_toggles", rnd_last_cnt, TOTAL);
            rnd_eps++;
            rnd_level_before = rnd_prev;
          end else begin
            checks++;
            if ((edge_no - rnd_last_tog) < MINH || (edge_no - rnd_last_tog) > MINH + 15) begin
              failures++;
              $display("[TB] FAIL seg_range: got %0d, expected %0d..%0d", edge_no - rnd_last_tog,
                       MINH, MINH + 15);
            end
          end
          if (int'(bus_rnd.toggle_count_out) == TOTAL)
            checkOutput("episode_final", int'(bus_rnd.bouncy_out), int'(!rnd_level_before));
          rnd_last_tog = edge_no;
          rnd_last_cnt = int'(bus_rnd.toggle_count_out);
        end
        rnd_prev = bus_rnd.bouncy_out;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic c, input logic en);
    clean  = c;
    enable = en;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    det_tog.delete();
    busy_rise = -1;
    busy_fall = -1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitEdge(input int n);
    for (int k = 0; k < 2000 && edge_no != n; k++) @(negedge clk);
    if (edge_no != n) checkOutput("wait_edge", edge_no, n);
  endtask

  task automatic checkTogList(input string name, input int exp_list[$]);
    checkOutput({name, "_len"}, det_tog.size(), exp_list.size());
    foreach (exp_list[k])
      checkOutput({name, "_edge"}, (k < det_tog.size()) ? det_tog[k] : -1, exp_list[k]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int exp_a[$];
    int exp_b[$];
    int waited;
    logic last_drive;

    applyReset();
    checkOutput("reset_out",   int'(bus_det.bouncy_out), 0);
    checkOutput("reset_busy",  int'(bus_det.busy), 0);
    checkOutput("reset_count", int'(bus_det.toggle_count_out), 0);
    checkOutput("reset_state", int'(bus_det.state_out), 0);

    $display("[TB] deterministic burst");
    waitEdge(9);
    applyStimulus(1'b1, 1'b1);
    waitEdge(35);
    exp_a = '{10, 13, 16, 19, 22};
    checkTogList("burst", exp_a);
    checkOutput("burst_final", int'(bus_det.bouncy_out), 1);
    checkOutput("burst_busy_rise", busy_rise, 10);
    checkOutput("burst_busy_fall", busy_fall, 30);
    checkOutput("burst_idle_state", int'(bus_det.state_out), 0);

    $display("[TB] change during episode");
    applyReset();
    waitEdge(9);
    applyStimulus(1'b1, 1'b1);
    waitEdge(14);
    applyStimulus(1'b0, 1'b1);
    waitEdge(55);
    exp_b = '{10, 13, 16, 19, 22, 30, 33, 36, 39, 42};
    checkTogList("rebound", exp_b);
    checkOutput("rebound_final", int'(bus_det.bouncy_out), 0);
    checkOutput("rebound_busy_fall", busy_fall, 50);

    $display("[TB] reset mid-bounce");
    applyReset();
    waitEdge(9);
    applyStimulus(1'b1, 1'b1);
    waitEdge(13);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_out",   int'(bus_det.bouncy_out), 0);
    checkOutput("midrst_busy",  int'(bus_det.busy), 0);
    checkOutput("midrst_state", int'(bus_det.state_out), 0);
    checkOutput("midrst_rnd_out", int'(bus_rnd.bouncy_out), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_out",   int'(bus_det.bouncy_out), 1);
    checkOutput("release_busy",  int'(bus_det.busy), 1);
    checkOutput("release_count", int'(bus_det.toggle_count_out), 1);

    $display("[TB] bypass");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      last_drive = clean;
      @(negedge clk);
      checkOutput("bypass_out",  int'(bus_det.bouncy_out), int'(last_drive));
      checkOutput("bypass_busy", int'(bus_det.busy), 0);
      clean = !clean;
    end
    @(negedge clk);
    enable = 1'b1;

    $display("[TB] random widths");
    rnd_phase = 1'b1;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(1, 100)) @(negedge clk);
      clean = !clean;
    end
    waited = 0;
    while ((bus_det.busy || bus_rnd.busy || bus_det.bouncy_out != clean ||
            bus_rnd.bouncy_out != clean) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("final_det_level", int'(bus_det.bouncy_out), int'(clean));
    checkOutput("final_rnd_level", int'(bus_rnd.bouncy_out), int'(clean));
    checkOutput("final_rnd_busy",  int'(bus_rnd.busy), 0);
    checkOutput("rnd_episode_seen", int'(rnd_eps > 10), 1);
    rnd_phase = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
